// File: rtl/uart_rx_if.sv
// Host-side bus of the UART receiver: FIFO read port, sticky error flags and interrupt.
// Combinational view of receiver state; the host pops by pulsing rd_en, no backpressure toward rx.
interface uart_rx_if;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] rd_data;
    logic       rx_valid;
    logic       full;
    logic       overrun;
    logic       frame_err;
    logic       irq;

    modport master (
        output rd_en, err_clr,
        input  rd_data, rx_valid, full, overrun, frame_err, irq
    );
    modport slave (
        input  rd_en, err_clr,
        output rd_data, rx_valid, full, overrun, frame_err, irq
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a first-word fall-through receive FIFO and sticky error flags.
// Byte visible 2+HALF+9*CPB+1 cycles after the rx fall; a full FIFO drops the byte and sets overrun.
module uart_rx #(
    parameter int CLK_FREQ   = 10_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     rx,
    uart_rx_if.slave bus
);
    localparam int CPB  = CLK_FREQ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW   = (CPB > 2) ? $clog2(CPB) : 1;
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW   = (FIFO_DEPTH > 0) ? $clog2(FIFO_DEPTH + 1) : 1;

    localparam logic [CW-1:0] C_HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] C_CPB_M1  = CW'(CPB - 1);
    localparam logic [PW-1:0] C_LAST    = PW'(FIFO_DEPTH - 1);
    localparam logic [NW-1:0] C_DEPTH   = NW'(FIFO_DEPTH);

    if (FIFO_DEPTH < 1) begin : g_bad_depth
        $error("uart_rx: FIFO_DEPTH must be at least 1");
    end
    if (CPB < 2) begin : g_bad_cpb
        $error("uart_rx: CLK_FREQ/BAUD must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic          r_sync1, r_sync2;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_head, r_tail;
    logic [NW-1:0] r_count;
    logic          r_overrun, r_frame_err;

    logic w_rx_s, w_stop_smp, w_push, w_frame, w_empty, w_full, w_pop, w_wr, w_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end
    assign w_rx_s = r_sync2;

    // r_cnt counts down to the next sample point: HALF into the start bit, then one CPB per bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= START;
                        r_cnt   <= C_HALF_M1;
                    end
                end
                START: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (w_rx_s) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= DATA;
                        r_cnt   <= C_CPB_M1;
                        r_bit   <= '0;
                    end
                end
                DATA: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_shift <= {w_rx_s, r_shift[7:1]};
                        r_cnt   <= C_CPB_M1;
                        if (r_bit == 3'd7) r_state <= STOP;
                        else               r_bit   <= r_bit + 1'b1;
                    end
                end
                STOP: begin
                    if (r_cnt != '0) r_cnt   <= r_cnt - 1'b1;
                    else             r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_stop_smp = (r_state == STOP) && (r_cnt == '0);
    assign w_push     = w_stop_smp && w_rx_s;
    assign w_frame    = w_stop_smp && !w_rx_s;
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == C_DEPTH);
    assign w_pop      = bus.rd_en && !w_empty;
    // A pop in the push cycle frees the slot, so a full FIFO still accepts the byte.
    assign w_wr       = w_push && (!w_full || w_pop);
    assign w_drop     = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_tail] <= r_shift;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr)  r_tail <= (r_tail == C_LAST) ? '0 : r_tail + 1'b1;
            if (w_pop) r_head <= (r_head == C_LAST) ? '0 : r_head + 1'b1;
            if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_drop)           r_overrun <= 1'b1;
            else if (bus.err_clr) r_overrun <= 1'b0;
            if (w_frame)          r_frame_err <= 1'b1;
            else if (bus.err_clr) r_frame_err <= 1'b0;
        end
    end

    assign bus.rd_data   = w_empty ? 8'h00 : r_mem[r_head];
    assign bus.rx_valid  = !w_empty;
    assign bus.full      = w_full;
    assign bus.overrun   = r_overrun;
    assign bus.frame_err = r_frame_err;
    assign bus.irq       = !w_empty | r_overrun | r_frame_err;
endmodule
